// File: rtl/alu_share_arb.sv
// Shares one MUL64 and one MOD unit between INV_MOD (req 0) and ADD_DOUBLE (req 1).
// Each unit has its own round-robin channel with hold-until-done and a BUSY watchdog.

module alu_share_arb_ch #(
    parameter int DW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req,
    input  logic [DW-1:0] op0,
    input  logic [DW-1:0] op1,
    input  logic          unit_done,
    output logic          enable,
    output logic [DW-1:0] op_out,
    output logic [1:0]    req_done,
    output logic          owner,
    output logic          timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    state_t        state;
    logic          last_grant;
    logic [TW-1:0] wd;
    logic [TW-1:0] wd_next;
    logic          grant;
    logic          wd_fire;

    // On a tie the requester that did not win last time gets the unit.
    assign grant   = (req == 2'b11) ? ~last_grant : req[1];
    assign wd_next = wd + 1'b1;
    assign wd_fire = (TIMEOUT != 0) && (wd_next == TW'(TIMEOUT));
    assign op_out  = (state == BUSY) ? (owner ? op1 : op0) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            enable      <= 1'b0;
            req_done    <= 2'b00;
            timeout_err <= 1'b0;
            wd          <= '0;
        end else begin
            req_done <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner      <= grant;
                        last_grant <= grant;
                        enable     <= 1'b1;
                        wd         <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    wd <= wd_next;
                    // A real done takes priority over a watchdog expiry in the same cycle.
                    if (unit_done || wd_fire) begin
                        req_done <= owner ? 2'b10 : 2'b01;
                        enable   <= 1'b0;
                        state    <= RELEASE;
                        if (!unit_done)
                            timeout_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

module alu_share_arb #(
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_mul_enable,
    input  logic [127:0]   req_mul1,
    input  logic [127:0]   req_mul2,
    input  logic [1:0]     req_mul1_sign,
    input  logic [1:0]     req_mul2_sign,
    output logic [1:0]     req_mul_done,
    input  logic [1:0]     req_mod_enable,
    input  logic [255:0]   req_mod_input,
    input  logic [1:0]     req_mod_input_sign,
    output logic [1:0]     req_mod_done,
    output logic           mul_enable,
    output logic [63:0]    mul_mul1,
    output logic [63:0]    mul_mul2,
    output logic           mul_mul1_sign,
    output logic           mul_mul2_sign,
    input  logic           mul_done,
    output logic           mod_enable,
    output logic [127:0]   mod_a,
    output logic           mod_a_sign,
    input  logic           mod_done,
    output logic           mul_owner,
    output logic           mod_owner,
    output logic [1:0]     timeout_err
);

    logic [129:0] mul_op0, mul_op1, mul_op;
    logic [128:0] mod_op0, mod_op1, mod_op;
    logic         mul_err, mod_err;

    assign mul_op0 = {req_mul1_sign[0], req_mul2_sign[0], req_mul1[63:0],   req_mul2[63:0]};
    assign mul_op1 = {req_mul1_sign[1], req_mul2_sign[1], req_mul1[127:64], req_mul2[127:64]};
    assign {mul_mul1_sign, mul_mul2_sign, mul_mul1, mul_mul2} = mul_op;

    assign mod_op0 = {req_mod_input_sign[0], req_mod_input[127:0]};
    assign mod_op1 = {req_mod_input_sign[1], req_mod_input[255:128]};
    assign {mod_a_sign, mod_a} = mod_op;

    assign timeout_err = {mod_err, mul_err};

    alu_share_arb_ch #(.DW(130), .TIMEOUT(TIMEOUT), .TW(TW)) u_mul_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_mul_enable),
        .op0         (mul_op0),
        .op1         (mul_op1),
        .unit_done   (mul_done),
        .enable      (mul_enable),
        .op_out      (mul_op),
        .req_done    (req_mul_done),
        .owner       (mul_owner),
        .timeout_err (mul_err)
    );

    alu_share_arb_ch #(.DW(129), .TIMEOUT(TIMEOUT), .TW(TW)) u_mod_ch (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_mod_enable),
        .op0         (mod_op0),
        .op1         (mod_op1),
        .unit_done   (mod_done),
        .enable      (mod_enable),
        .op_out      (mod_op),
        .req_done    (req_mod_done),
        .owner       (mod_owner),
        .timeout_err (mod_err)
    );

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb with TIMEOUT=8 so watchdog expiry is reachable quickly.

module tb_alu_share_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_mul_enable;
    logic [127:0] req_mul1, req_mul2;
    logic [1:0]   req_mul1_sign, req_mul2_sign;
    logic [1:0]   req_mul_done;
    logic [1:0]   req_mod_enable;
    logic [255:0] req_mod_input;
    logic [1:0]   req_mod_input_sign;
    logic [1:0]   req_mod_done;
    logic         mul_enable;
    logic [63:0]  mul_mul1, mul_mul2;
    logic         mul_mul1_sign, mul_mul2_sign;
    logic         mul_done;
    logic         mod_enable;
    logic [127:0] mod_a;
    logic         mod_a_sign;
    logic         mod_done;
    logic         mul_owner, mod_owner;
    logic [1:0]   timeout_err;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.TIMEOUT(8), .TW(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_mul_enable     (req_mul_enable),
        .req_mul1           (req_mul1),
        .req_mul2           (req_mul2),
        .req_mul1_sign      (req_mul1_sign),
        .req_mul2_sign      (req_mul2_sign),
        .req_mul_done       (req_mul_done),
        .req_mod_enable     (req_mod_enable),
        .req_mod_input      (req_mod_input),
        .req_mod_input_sign (req_mod_input_sign),
        .req_mod_done       (req_mod_done),
        .mul_enable         (mul_enable),
        .mul_mul1           (mul_mul1),
        .mul_mul2           (mul_mul2),
        .mul_mul1_sign      (mul_mul1_sign),
        .mul_mul2_sign      (mul_mul2_sign),
        .mul_done           (mul_done),
        .mod_enable         (mod_enable),
        .mod_a              (mod_a),
        .mod_a_sign         (mod_a_sign),
        .mod_done           (mod_done),
        .mul_owner          (mul_owner),
        .mod_owner          (mod_owner),
        .timeout_err        (timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        req_mul_enable     = 2'b00;
        req_mul1           = '0;
        req_mul2           = '0;
        req_mul1_sign      = 2'b00;
        req_mul2_sign      = 2'b00;
        req_mod_enable     = 2'b00;
        req_mod_input      = '0;
        req_mod_input_sign = 2'b00;
        mul_done           = 1'b0;
        mod_done           = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({mul_enable, mod_enable, req_mul_done, req_mod_done, mul_owner, mod_owner, timeout_err} !== 10'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {mul_enable, mod_enable, req_mul_done, req_mod_done, mul_owner, mod_owner, timeout_err});
        end
        checks++;
        if ({mul_mul1, mul_mul2, mod_a, mul_mul1_sign, mul_mul2_sign, mod_a_sign} !== 259'b0) begin
            fails++;
            $display("[TB] FAIL reset_operands: got nonzero, expected 0");
        end
        // spurious unit done in IDLE must be ignored
        mul_done = 1'b1;
        mod_done = 1'b1;
        tick();
        mul_done = 1'b0;
        mod_done = 1'b0;
        tick();
        checks++;
        if ({req_mul_done, req_mod_done, mul_enable, mod_enable} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL spurious_done: got %b expected 000000", {req_mul_done, req_mod_done, mul_enable, mod_enable});
        end
    endtask

    task automatic test_single_mul();
        do_reset();
        req_mul1       = {64'hAAAA_0000_0000_0001, 64'd5};
        req_mul2       = {64'hBBBB_0000_0000_0002, 64'd7};
        req_mul1_sign  = 2'b10;
        req_mul2_sign  = 2'b10;
        req_mul_enable = 2'b01;
        checks++;
        if (mul_enable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_c0_enable: got %b expected 0", mul_enable);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({mul_enable, mul_owner, req_mul_done, mul_mul1, mul_mul2, mul_mul1_sign, mul_mul2_sign} !==
                {1'b1, 1'b0, 2'b00, 64'd5, 64'd7, 2'b00}) begin
                fails++;
                $display("[TB] FAIL single_busy_c%0d: en=%b own=%b done=%b m1=%0d m2=%0d expected en=1 own=0 done=00 m1=5 m2=7",
                         c, mul_enable, mul_owner, req_mul_done, mul_mul1, mul_mul2);
            end
            if (c == 3) mul_done = 1'b1;
        end
        tick();
        mul_done       = 1'b0;
        req_mul_enable = 2'b00;
        checks++;
        if ({req_mul_done, mul_enable, mul_owner, mul_mul1} !== {2'b01, 1'b0, 1'b0, 64'd0}) begin
            fails++;
            $display("[TB] FAIL single_done_c4: done=%b en=%b own=%b m1=%0d expected done=01 en=0 own=0 m1=0",
                     req_mul_done, mul_enable, mul_owner, mul_mul1);
        end
        tick();
        checks++;
        if ({req_mul_done, mul_enable} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL single_c5: done=%b en=%b expected 00 0", req_mul_done, mul_enable);
        end
    endtask

    task automatic test_tie_mul();
        do_reset();
        req_mul1       = {64'd22, 64'd11};
        req_mul2       = {64'd44, 64'd33};
        req_mul_enable = 2'b11;
        tick();
        checks++;
        if ({mul_enable, mul_owner, mul_mul1} !== {1'b1, 1'b0, 64'd11}) begin
            fails++;
            $display("[TB] FAIL tie_first: en=%b own=%b m1=%0d expected en=1 own=0 m1=11", mul_enable, mul_owner, mul_mul1);
        end
        mul_done = 1'b1;
        tick();
        mul_done       = 1'b0;
        req_mul_enable = 2'b10;
        checks++;
        if ({req_mul_done, mul_enable} !== 3'b010) begin
            fails++;
            $display("[TB] FAIL tie_done0: done=%b en=%b expected 01 0", req_mul_done, mul_enable);
        end
        tick();
        checks++;
        if ({req_mul_done, mul_enable} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL tie_gap: done=%b en=%b expected 00 0", req_mul_done, mul_enable);
        end
        tick();
        checks++;
        if ({mul_enable, mul_owner, mul_mul1, mul_mul2} !== {1'b1, 1'b1, 64'd22, 64'd44}) begin
            fails++;
            $display("[TB] FAIL tie_second: en=%b own=%b m1=%0d m2=%0d expected en=1 own=1 m1=22 m2=44",
                     mul_enable, mul_owner, mul_mul1, mul_mul2);
        end
        mul_done = 1'b1;
        tick();
        mul_done       = 1'b0;
        req_mul_enable = 2'b00;
        checks++;
        if ({req_mul_done, mul_enable, mul_owner} !== 4'b1001) begin
            fails++;
            $display("[TB] FAIL tie_done1: done=%b en=%b own=%b expected 10 0 1", req_mul_done, mul_enable, mul_owner);
        end
        tick();
    endtask

    task automatic test_mod_alternate();
        logic [127:0] exp_a;
        do_reset();
        req_mod_input      = {128'hDEAD_BEEF, 128'h1234_5678};
        req_mod_input_sign = 2'b10;
        req_mod_enable     = 2'b11;
        tick();
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 1) ? 128'hDEAD_BEEF : 128'h1234_5678;
            checks++;
            if ({mod_enable, mod_owner, mod_a_sign, mod_a} !== {1'b1, i[0], i[0], exp_a}) begin
                fails++;
                $display("[TB] FAIL mod_alt_grant%0d: en=%b own=%b sign=%b a=%h expected en=1 own=%0d sign=%0d a=%h",
                         i, mod_enable, mod_owner, mod_a_sign, mod_a, i % 2, i % 2, exp_a);
            end
            mod_done = 1'b1;
            tick();
            mod_done = 1'b0;
            if (i == 3) req_mod_enable = 2'b00;
            checks++;
            if ({req_mod_done, mod_enable} !== {(i[0] ? 2'b10 : 2'b01), 1'b0}) begin
                fails++;
                $display("[TB] FAIL mod_alt_done%0d: done=%b en=%b expected owner %0d pulse, en=0",
                         i, req_mod_done, mod_enable, i % 2);
            end
            tick();
            tick();
        end
        checks++;
        if ({mod_enable, req_mod_done, mod_a} !== 131'b0) begin
            fails++;
            $display("[TB] FAIL mod_alt_idle: en=%b done=%b expected idle with mod_a=0", mod_enable, req_mod_done);
        end
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        req_mod_enable = 2'b01;
        tick();
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) mod_done = 1'b1;
            tick();
        end
        mod_done       = 1'b0;
        req_mod_enable = 2'b00;
        checks++;
        if ({req_mod_done, timeout_err} !== 4'b0100) begin
            fails++;
            $display("[TB] FAIL done_wins_timeout: done=%b err=%b expected 01 00", req_mod_done, timeout_err);
        end
        tick();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req_mul_enable = 2'b01;
        tick();
        for (int c = 1; c <= 8; c++) begin
            checks++;
            if ({mul_enable, req_mul_done, timeout_err} !== 5'b10000) begin
                fails++;
                $display("[TB] FAIL timeout_busy_c%0d: en=%b done=%b err=%b expected 1 00 00",
                         c, mul_enable, req_mul_done, timeout_err);
            end
            tick();
        end
        req_mul_enable = 2'b00;
        checks++;
        if ({mul_enable, req_mul_done, timeout_err} !== 5'b00101) begin
            fails++;
            $display("[TB] FAIL timeout_fire: en=%b done=%b err=%b expected 0 01 01", mul_enable, req_mul_done, timeout_err);
        end
        tick();
        tick();
        req_mul_enable = 2'b01;
        tick();
        checks++;
        if ({mul_enable, mul_owner, timeout_err} !== 4'b1001) begin
            fails++;
            $display("[TB] FAIL timeout_next_grant: en=%b own=%b err=%b expected 1 0 01", mul_enable, mul_owner, timeout_err);
        end
        mul_done = 1'b1;
        tick();
        mul_done       = 1'b0;
        req_mul_enable = 2'b00;
        checks++;
        if ({req_mul_done, timeout_err} !== 4'b0101) begin
            fails++;
            $display("[TB] FAIL timeout_sticky: done=%b err=%b expected 01 01", req_mul_done, timeout_err);
        end
        tick();
    endtask

    task automatic test_concurrent();
        do_reset();
        req_mod_input  = {128'h77, 128'h66};
        req_mul_enable = 2'b01;
        req_mod_enable = 2'b10;
        tick();
        checks++;
        if ({mul_enable, mod_enable, mul_owner, mod_owner, mod_a} !== {4'b1101, 128'h77}) begin
            fails++;
            $display("[TB] FAIL concurrent_grant: mulen=%b moden=%b mulown=%b modown=%b a=%h expected 1 1 0 1 77",
                     mul_enable, mod_enable, mul_owner, mod_owner, mod_a);
        end
        tick();
        mul_done = 1'b1;
        mod_done = 1'b1;
        tick();
        mul_done       = 1'b0;
        mod_done       = 1'b0;
        req_mul_enable = 2'b00;
        req_mod_enable = 2'b00;
        checks++;
        if ({req_mul_done, req_mod_done, mul_enable, mod_enable} !== 6'b011000) begin
            fails++;
            $display("[TB] FAIL concurrent_done: muldone=%b moddone=%b en=%b%b expected 01 10 00",
                     req_mul_done, req_mod_done, mul_enable, mod_enable);
        end
        tick();
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        req_mul_enable = 2'b10;
        tick();
        tick();
        checks++;
        if ({mul_enable, mul_owner} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL midrst_busy: en=%b own=%b expected 1 1", mul_enable, mul_owner);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mul_enable, req_mul_done, mul_owner} !== 4'b0) begin
            fails++;
            $display("[TB] FAIL midrst_async: en=%b done=%b own=%b expected 0 00 0", mul_enable, req_mul_done, mul_owner);
        end
        req_mul_enable = 2'b00;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({mul_enable, req_mul_done} !== 3'b000) begin
            fails++;
            $display("[TB] FAIL midrst_no_done: en=%b done=%b expected 0 00", mul_enable, req_mul_done);
        end
        req_mul_enable = 2'b11;
        tick();
        checks++;
        if ({mul_enable, mul_owner} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL midrst_regrant: en=%b own=%b expected 1 0", mul_enable, mul_owner);
        end
        mul_done = 1'b1;
        tick();
        mul_done       = 1'b0;
        req_mul_enable = 2'b00;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_mul();
        test_tie_mul();
        test_mod_alternate();
        test_done_at_timeout();
        test_timeout();
        test_concurrent();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
